// File: rtl/fetch_queue_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_stage
// Description : Instruction fetch front end. Issues one instruction-memory
//               request at a time, queues returned words with their PCs in a
//               small FIFO and presents the head to decode. A redirect flushes
//               the queue, restarts fetch and drops a stale in-flight response.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       imem_req,
  output logic [XLEN-1:0]            imem_addr,
  input  logic                       imem_gnt,
  input  logic                       imem_rvalid,
  input  logic [XLEN-1:0]            imem_rdata,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [XLEN-1:0]            inst_data,
  output logic [XLEN-1:0]            inst_pc,
  output logic [$clog2(DEPTH+1)-1:0] fq_count
);

  localparam int unsigned     CW      = $clog2(DEPTH + 1);
  localparam int unsigned     PW      = $clog2(DEPTH);
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
  localparam logic [XLEN-1:0] STEP_C  = XLEN'(PC_STEP);

  // Architectural state
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q,   req_pc_d;
  logic            outst_q,    outst_d;
  logic            drop_q,     drop_d;
  logic [CW-1:0]   count_q,    count_d;
  logic [PW-1:0]   wr_ptr_q,   wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q,   rd_ptr_d;

  // Queue storage; contents are don't-care while the entry is unoccupied
  logic [XLEN-1:0] data_q [DEPTH];
  logic [XLEN-1:0] pcs_q  [DEPTH];

  logic w_req;
  logic w_grant;
  logic w_rsp;
  logic w_push;
  logic w_pop;

  // Request/handshake decode; the pop of this cycle does not earn a new request
  always_comb begin
    w_req   = rst_n & ~outst_q & ~redirect_valid & (count_q < DEPTH_C);
    w_grant = w_req & imem_gnt;
    w_rsp   = imem_rvalid & outst_q;
    w_push  = w_rsp & ~drop_q & ~redirect_valid;
    w_pop   = (count_q != '0) & inst_ready & ~redirect_valid;
  end

  // Next-state computation; redirect overrides push, pop and grant
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      if (w_rsp) begin
        // Response landing with the redirect is simply discarded
        outst_d = 1'b0;
        drop_d  = 1'b0;
      end else begin
        // Still in flight: remember to throw its response away
        drop_d = drop_q | outst_q;
      end
    end else begin
      if (w_rsp) begin
        outst_d = 1'b0;
        drop_d  = 1'b0;
      end
      if (w_grant) begin
        outst_d    = 1'b1;
        req_pc_d   = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + STEP_C;
      end
      if (w_push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (w_push && !w_pop) begin
        count_d = count_q + CW'(1);
      end else if (w_pop && !w_push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // Control state register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      outst_q    <= 1'b0;
      drop_q     <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Write accepted response word and its PC at the queue tail
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      data_q[wr_ptr_q] <= imem_rdata;
      pcs_q[wr_ptr_q]  <= req_pc_q;
    end
  end

  // Output drive: memory address follows fetch_pc, decode sees the head
  always_comb begin
    imem_req   = w_req;
    imem_addr  = fetch_pc_q;
    inst_valid = (count_q != '0);
    inst_data  = data_q[rd_ptr_q];
    inst_pc    = pcs_q[rd_ptr_q];
    fq_count   = count_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue_stage
// Description : Self-checking bench for fetch_queue_stage. A queue-based
//               reference model tracks expected fetch PC, in-flight state and
//               queued {pc,word} entries; an in-order memory model answers
//               grants with 1..3 cycles of latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue_stage;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [2:0]  fq_count;

  always #5 clk = ~clk;

  fetch_queue_stage #(
    .XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC), .PC_STEP(1)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_data(inst_data), .inst_pc(inst_pc), .fq_count(fq_count)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_fetch;
  logic [31:0] m_req_pc;
  bit          m_outst;
  bit          m_drop;
  logic [63:0] m_q[$];

  // Memory environment: in-order pending addresses and delay of the front one
  logic [31:0] env_q[$];
  int          env_cnt;

  // Stimulus knobs (percent, reset in per-mille) and forced events
  int          p_gnt, p_ready, p_redir, p_sprv, p_rst;
  bit          f_redir, f_rst;
  logic [31:0] f_pc;
  bit          s_req;
  logic [31:0] s_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fail_bound(input string tag);
    n_assert++;
    n_fail++;
    $error("FAIL %s: observed=timeout expected=event", tag);
  endtask

  // One clock: drive at negedge, check at negedge+1, advance model at posedge
  task automatic cycle();
    logic exp_req;
    bit   pop, push;
    @(negedge clk);
    rst_n          = !(f_rst || ($urandom_range(0, 999) < p_rst));
    imem_gnt       = ($urandom_range(0, 99) < p_gnt);
    inst_ready     = ($urandom_range(0, 99) < p_ready);
    redirect_valid = f_redir || ($urandom_range(0, 99) < p_redir);
    if (f_redir) redirect_pc = f_pc;
    else begin
      case ($urandom_range(0, 3))
        0: redirect_pc = 32'h0000_0100;
        1: redirect_pc = 32'hFFFF_FFFF;
        2: redirect_pc = 32'hFFFF_FFFE;
        default: redirect_pc = $urandom;
      endcase
    end
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (env_q.size() > 0) begin
      if (env_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(env_q[0]);
        void'(env_q.pop_front());
        env_cnt = $urandom_range(0, 2);
      end else begin
        env_cnt--;
      end
    end else if ($urandom_range(0, 99) < p_sprv) begin
      imem_rvalid = 1'b1;
    end
    #1;
    exp_req = rst_n && !m_outst && !redirect_valid && (m_q.size() < DEPTH);
    chk("imem_req", imem_req, exp_req);
    if (exp_req) chk("imem_addr", imem_addr, m_fetch);
    chk("inst_valid", inst_valid, m_q.size() != 0);
    chk("fq_count", fq_count, m_q.size());
    if (m_q.size() > 0) begin
      chk("inst_data", inst_data, m_q[0][31:0]);
      chk("inst_pc", inst_pc, m_q[0][63:32]);
    end
    s_req  = imem_req;
    s_addr = imem_addr;
    @(posedge clk);
    if (s_req && imem_gnt) begin
      if (env_q.size() == 0) env_cnt = $urandom_range(0, 2);
      env_q.push_back(s_addr);
    end
    if (!rst_n) begin
      m_fetch = RESET_PC;
      m_q.delete();
      m_outst = 1'b0;
      m_drop  = 1'b0;
    end else if (redirect_valid) begin
      m_q.delete();
      m_fetch = redirect_pc;
      if (imem_rvalid && m_outst) begin
        m_outst = 1'b0;
        m_drop  = 1'b0;
      end else if (m_outst) begin
        m_drop = 1'b1;
      end
    end else begin
      pop  = (m_q.size() > 0) && inst_ready;
      push = 1'b0;
      if (imem_rvalid && m_outst) begin
        push    = !m_drop;
        m_outst = 1'b0;
        m_drop  = 1'b0;
      end
      if (pop)  void'(m_q.pop_front());
      if (push) m_q.push_back({m_req_pc, imem_rdata});
      if (exp_req && imem_gnt) begin
        m_outst  = 1'b1;
        m_req_pc = m_fetch;
        m_fetch  = m_fetch + 32'd1;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; inst_ready = 1'b0;
    m_fetch = RESET_PC; m_req_pc = RESET_PC; m_outst = 1'b0; m_drop = 1'b0;
    env_cnt = 0;
    p_gnt = 0; p_ready = 0; p_redir = 0; p_sprv = 0; p_rst = 0;
    f_redir = 1'b0; f_rst = 1'b0; f_pc = '0;

    // Reset, then first request must come straight from RESET_PC
    f_rst = 1'b1;
    repeat (3) cycle();
    f_rst = 1'b0;
    p_gnt = 100; p_ready = 100;
    cycle();
    chk("first_req", s_req, 1'b1);
    chk("first_addr", s_addr, RESET_PC);
    repeat (20) cycle();

    // Decode stalled: queue fills to DEPTH and requests stop
    p_ready = 0;
    repeat (20) cycle();
    #1;
    chk("full_count", fq_count, DEPTH);
    chk("full_req", imem_req, 1'b0);
    p_ready = 100;
    cycle();
    p_ready = 0;
    #1;
    chk("refill_req", imem_req, 1'b1);
    cycle();
    cycle();

    // Redirect to 0x100 while work is queued / in flight
    f_redir = 1'b1; f_pc = 32'h0000_0100;
    cycle();
    f_redir = 1'b0;
    #1;
    chk("redir_count", fq_count, 0);
    p_ready = 100;
    begin
      int k;
      for (k = 0; k < 20 && m_q.size() == 0; k++) cycle();
      if (m_q.size() == 0) fail_bound("redir_push");
      else begin
        #1;
        chk("redir_inst_pc", inst_pc, 32'h0000_0100);
      end
    end

    // PC wrap at the top of the address space
    f_redir = 1'b1; f_pc = 32'hFFFF_FFFF;
    cycle();
    f_redir = 1'b0;
    begin
      int k;
      for (k = 0; k < 20 && m_fetch != 32'h0; k++) cycle();
      if (m_fetch != 32'h0) fail_bound("wrap_grant");
      else begin
        #1;
        chk("wrap_addr", imem_addr, 32'h0);
      end
    end

    // Reset while a request is in flight; its late response must be ignored
    p_gnt = 100; p_ready = 0;
    cycle();
    f_rst = 1'b1; p_gnt = 0;
    cycle();
    f_rst = 1'b0;
    repeat (6) cycle();
    #1;
    chk("post_rst_count", fq_count, 0);
    chk("post_rst_addr", imem_addr, RESET_PC);

    // Randomised traffic
    p_gnt = 70; p_ready = 60; p_redir = 5; p_sprv = 5; p_rst = 10;
    repeat (3000) cycle();
    p_redir = 0; p_rst = 0; p_sprv = 0; p_gnt = 100; p_ready = 100;
    repeat (20) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_queue_stage.md
FETCH_QUEUE_STAGE -- requirements
Module: fetch_queue_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, PC and instruction width.
REQ-002 SHALL have parameter DEPTH, default 4, instruction-queue entries; power of 2, >= 2.
REQ-003 SHALL have parameter RESET_PC, default 0, fetch PC after reset.
REQ-004 SHALL have parameter PC_STEP, default 1, PC increment per fetch (word addressing).
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-007 SHALL have port redirect_valid  input  1  flush and restart fetch (branch/jump).
REQ-008 SHALL have port redirect_pc  input  XLEN  new fetch PC when redirect_valid=1.
REQ-009 SHALL have port imem_req  output  1  instruction-memory request.
REQ-010 SHALL have port imem_addr  output  XLEN  request address, equal to fetch_pc.
REQ-011 SHALL have port imem_gnt  input  1  request accepted when imem_req & imem_gnt.
REQ-012 SHALL have port imem_rvalid  input  1  response valid, >= 1 cycle after grant, in order.
REQ-013 SHALL have port imem_rdata  input  XLEN  response instruction word.
REQ-014 SHALL have port inst_valid  output  1  queue head valid (queue non-empty).
REQ-015 SHALL have port inst_ready  input  1  decode accepts head.
REQ-016 SHALL have port inst_data  output  XLEN  head instruction.
REQ-017 SHALL have port inst_pc  output  XLEN  PC of head instruction.
REQ-018 SHALL have port fq_count  output  $clog2(DEPTH+1)  occupied entries.

Function
REQ-019 SHALL keep at most one memory request outstanding (granted, no rvalid yet).
REQ-020 SHALL assert imem_req iff no outstanding request, redirect_valid=0, and fq_count + 0 < DEPTH using registered count (pop in the same cycle not credited).
REQ-021 SHALL hold imem_addr stable while imem_req=1 and imem_gnt=0.
REQ-022 SHALL on grant record the granted address as req_pc, set outstanding, and set fetch_pc to fetch_pc + PC_STEP modulo 2^XLEN (wrap, no error).
REQ-023 SHALL on imem_rvalid with outstanding set and drop clear push {req_pc, imem_rdata} at queue tail and clear outstanding.
REQ-024 SHALL ignore imem_rvalid when outstanding is clear (no push, no state change).
REQ-025 SHALL pop the head when inst_valid & inst_ready; a simultaneous push and pop leaves fq_count unchanged and preserves order.
REQ-026 SHALL drive inst_data/inst_pc from the head entry; values are don't-care when inst_valid=0.
REQ-027 SHALL never overflow: push occurs only into space reserved by REQ-020.
REQ-028 SHALL on redirect_valid=1: empty the queue (fq_count=0, inst_valid=0 next cycle), set fetch_pc=redirect_pc, deassert imem_req that cycle, and ignore inst_ready.
REQ-029 SHALL on redirect with a request outstanding (or granted in that cycle is impossible per REQ-020), set drop; the next rvalid is discarded and clears both drop and outstanding.
REQ-030 SHALL discard an rvalid arriving in the same cycle as redirect_valid, clearing outstanding and not setting drop.
REQ-031 SHALL give redirect priority over push, pop and grant in the same cycle.
REQ-032 SHALL issue the first request from redirect_pc the cycle after redirect, once no request is outstanding.
REQ-033 SHALL wrap queue read/write pointers modulo DEPTH.

Reset
REQ-034 SHALL when rst_n=0 at a clock edge set fetch_pc=RESET_PC, fq_count=0, inst_valid=0, imem_req=0, outstanding=0, drop=0, pointers=0.
REQ-035 SHALL treat a response arriving after reset to a pre-reset request as per REQ-024 (ignored).
REQ-036 SHALL issue the first request (imem_addr=RESET_PC) in the first cycle after rst_n rises.

Verification
REQ-037 Reset release, gnt=1, rvalid 1 cycle after each grant, inst_ready=1 -> addresses 0,1,2,3... and inst_pc sequence 0,1,2,3 in order.
REQ-038 inst_ready=0, DEPTH=4 -> exactly 4 grants, fq_count=4, imem_req=0; one pop -> imem_req=1 the following cycle.
REQ-039 Redirect to 0x100 with request outstanding and 2 entries queued -> fq_count=0 next cycle, stale rvalid dropped, next imem_addr=0x100, next inst_pc=0x100.
REQ-040 Redirect in same cycle as rvalid -> response not queued, no drop pending, imem_addr=redirect_pc next cycle.
REQ-041 fetch_pc=0xFFFFFFFF, PC_STEP=1, grant -> next imem_addr=0x00000000.
REQ-042 rst_n=0 with request outstanding, rvalid arrives after release -> no push, fetch from RESET_PC.
